wb_arbiter_2m1s: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter that shares the on-chip RAM slave between the CPU instruction bus (M0) and data bus (M1).
- Sits between the CPU bus interfaces and the RAM slave.
- Serialises transactions and routes the slave response back to the granted master.
- Forces a one-cycle cyc/stb gap between transactions, because the RAM acks only on a request rising edge.

---
 rtl/wb_arbiter_2m1s_pkg.sv | 20 ++
 rtl/wb_arb_timeout.sv | 32 +++
 rtl/wb_arbiter_2m1s.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter_2m1s.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_2m1s_pkg.sv
// Shared encodings and Wishbone bus widths for the two-master RAM arbiter.
package wb_arbiter_2m1s_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  localparam logic [0:0] ARB_M0 = 1'b0;
  localparam logic [0:0] ARB_M1 = 1'b1;

  localparam int TMO_CNT_W = 16;

  function automatic logic [1:0] owner_gnt(input logic [0:0] owner);
    return (owner == ARB_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Slave no-ack watchdog; only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timeout
  import wb_arbiter_2m1s_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int CNT_W = TMO_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ack,
  output logic fire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Fires in the LIMIT-th consecutive BUSY cycle that saw no ack.
  assign fire = busy & ~ack & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!busy || ack || fire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter_2m1s.sv
// Two-master / one-slave Wishbone classic arbiter with a forced idle cycle between transactions.
// Optional slave timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m1s
  import wb_arbiter_2m1s_pkg::*;
#(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int SEL_W          = WB_SEL_W,
  parameter int PRIO_M1        = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic              m0_we_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_we_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_we_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  logic [0:0] state;
  logic [0:0] owner;
  logic [0:0] winner;
  logic       alt_valid;
  logic       req0;
  logic       req1;
  logic       busy;
  logic       own_cyc;
  logic       done;
  logic       tmo_fire;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign busy    = (state == ARB_BUSY);
  assign own_cyc = (owner == ARB_M1) ? m1_cyc_i : m0_cyc_i;
  assign done    = busy & (s_ack_i | ~own_cyc | tmo_fire);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .ack   (s_ack_i),
    .fire  (tmo_fire)
  );
`else
  assign tmo_fire = 1'b0;
`endif

  // alt_valid is only high in the single IDLE cycle right after a transaction;
  // any longer gap falls back to the fixed priority.
  always_comb begin
    winner = ARB_M0;
    if (req0 && req1) begin
      if (alt_valid) winner = ~owner;
      else           winner = (PRIO_M1 != 0) ? ARB_M1 : ARB_M0;
    end else if (req1) begin
      winner = ARB_M1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner     <= ARB_M0;
      alt_valid <= 1'b0;
    end else begin
      alt_valid <= done;
      case (state)
        ARB_IDLE: begin
          if (req0 || req1) begin
            state <= ARB_BUSY;
            owner <= winner;
          end
        end
        default: begin
          if (done) state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Slave side depends only on state/owner and master inputs, never on s_ack_i.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_err_o  = 1'b0;
    m0_data_o = '0;
    m1_data_o = '0;
    gnt_o     = 2'b00;
    if (busy) begin
      gnt_o = owner_gnt(owner);
      if (owner == ARB_M1) begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_stb_o   = m1_stb_i;
        s_cyc_o   = m1_cyc_i;
        m1_ack_o  = s_ack_i;
        m1_err_o  = tmo_fire;
        m1_data_o = tmo_fire ? '0 : s_data_i;
      end else begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_stb_o   = m0_stb_i;
        s_cyc_o   = m0_cyc_i;
        m0_ack_o  = s_ack_i;
        m0_err_o  = tmo_fire;
        m0_data_o = tmo_fire ? '0 : s_data_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Self-checking bench for wb_arbiter_2m1s with a RAM slave that acks on a request rising edge.
// The timeout scenario runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter_2m1s;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic        m_we [2];
  logic [3:0]  m_sel [2];
  logic        m_stb [2];
  logic        m_cyc [2];

  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] s_addr_o, s_data_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_rdata;
  logic        s_ack;
  logic [1:0]  gnt_o;

  always #5 clk = ~clk;

  wb_arbiter_2m1s #(
    .PRIO_M1        (1),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_addr_i (m_addr[0]),
    .m0_data_i (m_wdata[0]),
    .m0_we_i   (m_we[0]),
    .m0_sel_i  (m_sel[0]),
    .m0_stb_i  (m_stb[0]),
    .m0_cyc_i  (m_cyc[0]),
    .m0_data_o (m0_data_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_addr_i (m_addr[1]),
    .m1_data_i (m_wdata[1]),
    .m1_we_i   (m_we[1]),
    .m1_sel_i  (m_sel[1]),
    .m1_stb_i  (m_stb[1]),
    .m1_cyc_i  (m_cyc[1]),
    .m1_data_o (m1_data_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_stb_o   (s_stb_o),
    .s_cyc_o   (s_cyc_o),
    .s_data_i  (s_rdata),
    .s_ack_i   (s_ack),
    .gnt_o     (gnt_o)
  );

  // RAM slave: one registered ack per request rising edge.
  logic [31:0] ram [64];
  logic        ram_stb_q;
  logic        ram_ack_en;
  logic [5:0]  ram_idx;
  assign ram_idx = s_addr_o[7:2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_stb_q <= 1'b0;
      s_ack     <= 1'b0;
      s_rdata   <= '0;
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA500_0000 + 32'(i);
      ram[4] <= 32'hCAFE_BABE;
      ram[8] <= 32'h0000_0000;
    end else begin
      ram_stb_q <= s_cyc_o & s_stb_o;
      s_ack     <= ram_ack_en & s_cyc_o & s_stb_o & ~ram_stb_q;
      if (s_cyc_o && s_stb_o && !ram_stb_q) begin
        if (s_we_o) begin
          for (int b = 0; b < 4; b++)
            if (s_sel_o[b]) ram[ram_idx][8*b +: 8] <= s_data_o[8*b +: 8];
        end
        s_rdata <= ram[ram_idx];
      end
    end
  end

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [1:0] gnt_log[$];
  int         ack_cnt [2] = '{0, 0};
  int         err_cnt [2] = '{0, 0};
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] log_at(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : 2'bxx;
  endfunction

  // Output monitor: pops the scoreboard on every ack.
  initial begin
    exp_t       e;
    logic [1:0] prev_gnt = 2'b00;
    logic       prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m0_ack_o) begin
          ack_cnt[0]++;
          chk("m0_ack_gnt", 64'(gnt_o), 64'h1);
          if (q0.size() == 0) chk("m0_unexpected_ack", 64'(q0.size()), 64'd1);
          else begin
            e = q0.pop_front();
            if (e.is_read) chk("m0_rdata", 64'(m0_data_o), 64'(e.data));
          end
        end
        if (m1_ack_o) begin
          ack_cnt[1]++;
          chk("m1_ack_gnt", 64'(gnt_o), 64'h2);
          if (q1.size() == 0) chk("m1_unexpected_ack", 64'(q1.size()), 64'd1);
          else begin
            e = q1.pop_front();
            if (e.is_read) chk("m1_rdata", 64'(m1_data_o), 64'(e.data));
          end
        end
        if (m0_err_o) err_cnt[0]++;
        if (m1_err_o) err_cnt[1]++;
        if (gnt_o != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(gnt_o);
        if (prev_ack) chk("idle_gap_cyc", 64'(s_cyc_o), 64'd0);
        prev_gnt = gnt_o;
        prev_ack = s_ack;
      end else begin
        prev_gnt = 2'b00;
        prev_ack = 1'b0;
      end
    end
  end

  task automatic set_req(input int id, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] sel);
    m_addr[id]  = addr;
    m_wdata[id] = wdata;
    m_we[id]    = we;
    m_sel[id]   = sel;
    m_cyc[id]   = 1'b1;
    m_stb[id]   = 1'b1;
  endtask

  task automatic drop(input int id);
    m_cyc[id] = 1'b0;
    m_stb[id] = 1'b0;
    m_we[id]  = 1'b0;
  endtask

  task automatic push_exp(input int id, input bit is_read, input logic [31:0] data);
    exp_t e;
    e.is_read = is_read;
    e.data    = data;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic wait_acks(input int id, input int target, input int budget);
    int left = budget;
    while (ack_cnt[id] < target && left > 0) begin
      @(negedge clk);
      #1;
      left--;
    end
    chk($sformatf("m%0d_ack_wait", id), 64'(ack_cnt[id]), 64'(target));
  endtask

  // Holds the request across n back-to-back transactions, then releases it.
  task automatic master_txns(input int id, input int n, input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic [3:0] sel, input logic [31:0] exp_rd);
    int target;
    for (int i = 0; i < n; i++) push_exp(id, !we, exp_rd);
    @(posedge clk);
    #1;
    set_req(id, addr, we, wdata, sel);
    target = ack_cnt[id] + n;
    wait_acks(id, target, 40 * n);
    @(posedge clk);
    #1;
    drop(id);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base0, base1, cnt;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_we[i] = 1'b0; m_sel[i] = '0;
      m_stb[i] = 1'b0; m_cyc[i] = 1'b0;
    end
    ram_ack_en = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_m0_ack", 64'(m0_ack_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single M0 read: latency and idle cycle afterwards.
    @(posedge clk);
    #1;
    push_exp(0, 1'b1, 32'hCAFE_BABE);
    set_req(0, 32'h0000_0010, 1'b0, '0, 4'hF);
    @(negedge clk);
    chk("t1_gnt_before", 64'(gnt_o), 64'd0);
    @(negedge clk);
    chk("t1_gnt_busy", 64'(gnt_o), 64'h1);
    chk("t1_s_stb", 64'(s_stb_o), 64'd1);
    chk("t1_s_addr", 64'(s_addr_o), 64'h10);
    chk("t1_ack_early", 64'(m0_ack_o), 64'd0);
    @(negedge clk);
    chk("t1_ack", 64'(m0_ack_o), 64'd1);
    @(posedge clk);
    #1;
    drop(0);
    @(negedge clk);
    chk("t1_s_cyc_idle", 64'(s_cyc_o), 64'd0);
    repeat (3) @(posedge clk);

    // Simultaneous requests: M1 partial write first, then M0 reads it back.
    gnt_log.delete();
    fork
      master_txns(1, 1, 32'h0000_0020, 1'b1, 32'h1234_5678, 4'b0011, 32'h0);
      master_txns(0, 1, 32'h0000_0020, 1'b0, 32'h0, 4'hF, 32'h0000_5678);
    join
    chk("t2_n_grants", 64'(gnt_log.size()), 64'd2);
    chk("t2_gnt0", 64'(log_at(0)), 64'h2);
    chk("t2_gnt1", 64'(log_at(1)), 64'h1);
    repeat (3) @(posedge clk);

    // Both masters streaming: grants must alternate starting with M1.
    gnt_log.delete();
    base0 = ack_cnt[0];
    base1 = ack_cnt[1];
    fork
      master_txns(0, 4, 32'h0000_0040, 1'b0, 32'h0, 4'hF, 32'hA500_0010);
      master_txns(1, 4, 32'h0000_0044, 1'b0, 32'h0, 4'hF, 32'hA500_0011);
    join
    chk("t3_n_grants", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_gnt%0d", i), 64'(log_at(i)), (i % 2 == 0) ? 64'h2 : 64'h1);
    chk("t3_m0_acks", 64'(ack_cnt[0] - base0), 64'd4);
    chk("t3_m1_acks", 64'(ack_cnt[1] - base1), 64'd4);
    repeat (3) @(posedge clk);

    // M1 aborts in its first BUSY cycle; pending M0 is served next.
    gnt_log.delete();
    base0 = ack_cnt[0];
    base1 = ack_cnt[1];
    @(posedge clk);
    #1;
    push_exp(0, 1'b1, 32'hA500_0013);
    set_req(1, 32'h0000_0048, 1'b0, '0, 4'hF);
    set_req(0, 32'h0000_004C, 1'b0, '0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("t4_gnt_m1", 64'(gnt_o), 64'h2);
    #1;
    m_cyc[1] = 1'b0;
    @(negedge clk);
    chk("t4_idle_gnt", 64'(gnt_o), 64'd0);
    chk("t4_idle_cyc", 64'(s_cyc_o), 64'd0);
    drop(1);
    wait_acks(0, base0 + 1, 20);
    @(posedge clk);
    #1;
    drop(0);
    chk("t4_m1_no_ack", 64'(ack_cnt[1] - base1), 64'd0);
    chk("t4_gnt_next", 64'(log_at(1)), 64'h1);
    repeat (3) @(posedge clk);

    // Reset mid-BUSY, then fresh arbitration uses the fixed priority.
    @(posedge clk);
    #1;
    set_req(1, 32'h0000_0044, 1'b0, '0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("t5_gnt_busy", 64'(gnt_o), 64'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", 64'(gnt_o), 64'd0);
    chk("t5_rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("t5_rst_s_stb", 64'(s_stb_o), 64'd0);
    chk("t5_rst_s_addr", 64'(s_addr_o), 64'd0);
    chk("t5_rst_m1_ack", 64'(m1_ack_o), 64'd0);
    chk("t5_rst_m1_data", 64'(m1_data_o), 64'd0);
    drop(1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    fork
      master_txns(0, 1, 32'h0000_0040, 1'b0, 32'h0, 4'hF, 32'hA500_0010);
      master_txns(1, 1, 32'h0000_0044, 1'b0, 32'h0, 4'hF, 32'hA500_0011);
    join
    chk("t5_gnt0", 64'(log_at(0)), 64'h2);
    chk("t5_gnt1", 64'(log_at(1)), 64'h1);
    repeat (3) @(posedge clk);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: each owner gets exactly one err pulse, then the other is granted.
    ram_ack_en = 1'b0;
    gnt_log.delete();
    base0 = err_cnt[0];
    base1 = err_cnt[1];
    @(posedge clk);
    #1;
    set_req(0, 32'h0000_0040, 1'b0, '0, 4'hF);
    set_req(1, 32'h0000_0044, 1'b0, '0, 4'hF);
    cnt = 0;
    for (int i = 0; i < 60 && err_cnt[1] == base1; i++) begin
      @(negedge clk);
      #1;
      if (gnt_o == 2'b10) cnt++;
    end
    chk("t6_m1_busy_cycles", 64'(cnt), 64'd16);
    for (int i = 0; i < 60 && err_cnt[0] == base0; i++) begin
      @(negedge clk);
      #1;
    end
    drop(0);
    drop(1);
    repeat (3) @(posedge clk);
    chk("t6_m1_err_once", 64'(err_cnt[1] - base1), 64'd1);
    chk("t6_m0_err_once", 64'(err_cnt[0] - base0), 64'd1);
    chk("t6_gnt0", 64'(log_at(0)), 64'h2);
    chk("t6_gnt1", 64'(log_at(1)), 64'h1);
    ram_ack_en = 1'b1;
`else
    chk("no_err_m0", 64'(err_cnt[0]), 64'd0);
    chk("no_err_m1", 64'(err_cnt[1]), 64'd0);
`endif

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
